cla_adder_pipe: RTL and testbench
=================================

# cla_adder_pipe

Two-stage pipelined carry-lookahead adder with valid/ready handshake. Stage 1 registers per-bit and per-nibble generate/propagate terms. Stage 2 resolves nibble carries from those terms and registers sum, carry-out and overflow. The block sits between operand-issue logic and the result consumer in the arithmetic datapath. It is the registered producer of the group g/p vectors that the 4-bit lookahead logic consumes.

## Interface
- WIDTH, 16, operand width; must be a multiple of 4 and at least 4.
- i_clk  input  1  clock, all state on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  operand valid from upstream.
- o_ready  output  1  block can accept an operand this cycle.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_c  input  1  carry-in.
- o_valid  output  1  result valid to downstream.
- i_ready  input  1  downstream accepts result this cycle.
- o_s  output  WIDTH  sum.
- o_c  output  1  carry-out.
- o_ovf  output  1  signed two's-complement overflow.

## Operation
- Accept when i_valid && o_ready. Result transfer when o_valid && i_ready.
- Stage 1 register contents:
  - valid v1;
  - bit vectors g = a&b and p = a^b;
  - per-nibble group G/P, each of width WIDTH/4 (G = g3|p3g2|p3p2g1|p3p2p1g0, P = &p of the nibble);
  - carry-in;
  - MSB operand bits a[MSB] and b[MSB] for overflow.
- Stage 2 computation:
  - nibble carry c[0] = cin; c[k+1] = G[k] | P[k]&c[k].
  - Intra-nibble bit carries come from stage-1 bit g/p and c[k].
  - s = p ^ carries; o_c = c[WIDTH/4].
  - o_ovf = (a[MSB] == b[MSB]) && (s[MSB] != a[MSB]).
- Arithmetic is modulo 2^WIDTH; o_c is the (WIDTH+1)th bit.
- Flow control:
  - Stage 2 loads when !v2 || i_ready.
  - Stage 1 loads when !v1 || stage 2 loads.
  - o_ready = !v1 || !v2 || i_ready (combinational from i_ready).
- Data registers load only when their stage loads. When a stage loads with no incoming valid, its valid clears and its data holds.
- No data dropped or duplicated. Results leave in acceptance order.
- Held o_s/o_c/o_ovf stay stable while o_valid && !i_ready.

## Timing
- Reset (asynchronous, immediate):
  - v1 = v2 = 0.
  - All data registers 0, so o_valid = 0, o_s = 0, o_c = 0, o_ovf = 0.
  - o_ready = 1 once reset deasserts.
- Latency: operand accepted at edge N gives o_valid = 1 with its result after edge N+1, i.e. visible in the cycle after the second edge.
- Throughput: one result per cycle while i_ready = 1.
- Backpressure:
  - With i_ready held 0, the pipe absorbs exactly two operands, then o_ready = 0.
  - o_ready returns to 1 in the same cycle i_ready rises (simultaneous drain and accept).
- Simultaneous accept and transfer in one cycle is legal in every state.
- Reset mid-operation discards both in-flight operands. There is no partial output.
- Inputs i_a/i_b/i_c are sampled only on the accept edge. Values in other cycles are don't-care.

## Structure
- Shared package cla_pkg: localparam NIBBLE_W = 4, helper function for the nibble count (WIDTH/4), and a packed struct for the stage-1 register payload (g, p, G, P, cin, msb_a, msb_b), parameterised via WIDTH-dependent typedef in the module.
- One natural sub-module: pg_nibble. It maps 4-bit a/b to bit g/p and group G/P, is purely combinational, and is instantiated WIDTH/4 times in stage 1.
- Stage-2 carry resolution stays inline in the top module.

## Test plan
- WIDTH=16, accept 0x1234 + 0x4321, cin=0 -> o_valid two edges later, o_s=0x5555, o_c=0, o_ovf=0.
- 0xFFFF + 0x0000, cin=1 -> o_s=0x0000, o_c=1, o_ovf=0 (full propagate across all four nibbles).
- Overflow cases:
  - 0x7FFF + 0x0001, cin=0 -> o_s=0x8000, o_c=0, o_ovf=1.
  - 0x8000 + 0x8000 -> o_s=0x0000, o_c=1, o_ovf=1.
- Backpressure burst:
  - Issue 4 back-to-back operands (1+1, 2+2, 3+3, 4+4) with i_ready=0 for 3 cycles.
  - Required: o_ready drops after 2 accepts; o_s stable at 0x0002 while stalled; then 0x0002, 0x0004, 0x0006, 0x0008 in order, no gaps once i_ready=1.
- Reset mid-operation:
  - Assert i_rst asynchronously with both stages valid.
  - Required: o_valid and o_s go 0 immediately, without waiting for a clock edge; after release, first new operand 0x00FF+0x0001 -> 0x0100.

Source files
------------

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants, helpers and payload types for the pipelined CLA adder
package cla_pkg;

  localparam int NIBBLE_W = 4;

  function automatic int nibble_cnt(input int width);
    return width / NIBBLE_W;
  endfunction

  // Scalar part of the stage-1 payload; the WIDTH-dependent vectors are wrapped around it in the top.
  typedef struct packed {
    logic cin;
    logic msb_a;
    logic msb_b;
  } s1_ctl_t;

endpackage

// File: rtl/pg_nibble.sv
// rtl/pg_nibble.sv - combinational bit and group generate/propagate for one 4-bit slice
module pg_nibble
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  output logic [NIBBLE_W-1:0] g,
  output logic [NIBBLE_W-1:0] p,
  output logic                grp_g,
  output logic                grp_p
);

  assign g = a & b;
  assign p = a ^ b;

  assign grp_g = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;

endmodule

// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - two-stage pipelined carry-lookahead adder with valid/ready flow control
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_c,
  output logic             o_ovf
);

  localparam int NG = nibble_cnt(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    s1_ctl_t          ctl;
  } s1_t;

  logic [WIDTH-1:0] g_w;
  logic [WIDTH-1:0] p_w;
  logic [NG-1:0]    grp_g_w;
  logic [NG-1:0]    grp_p_w;
  s1_t              s1_d;
  s1_t              s1_q;
  logic             v1;
  logic             v2;
  logic             load1;
  logic             load2;

  logic [WIDTH-1:0] bit_c;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             carry;
  logic             bc;

  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             ovf_q;

  for (genvar k = 0; k < NG; k++) begin : g_nib
    pg_nibble u_pg (
      .a     (i_a[k*NIBBLE_W +: NIBBLE_W]),
      .b     (i_b[k*NIBBLE_W +: NIBBLE_W]),
      .g     (g_w[k*NIBBLE_W +: NIBBLE_W]),
      .p     (p_w[k*NIBBLE_W +: NIBBLE_W]),
      .grp_g (grp_g_w[k]),
      .grp_p (grp_p_w[k])
    );
  end

  always_comb begin
    s1_d           = '0;
    s1_d.g         = g_w;
    s1_d.p         = p_w;
    s1_d.grp_g     = grp_g_w;
    s1_d.grp_p     = grp_p_w;
    s1_d.ctl.cin   = i_c;
    s1_d.ctl.msb_a = i_a[WIDTH-1];
    s1_d.ctl.msb_b = i_b[WIDTH-1];
  end

  // A full pipe still accepts when the output drains in the same cycle.
  assign load2   = !v2 || i_ready;
  assign load1   = !v1 || load2;
  assign o_ready = load1;

  // Nibble carries ripple through group G/P only; bit carries fan out from each nibble's carry-in.
  always_comb begin
    bit_c = '0;
    carry = s1_q.ctl.cin;
    bc    = 1'b0;
    for (int k = 0; k < NG; k++) begin
      bc = carry;
      for (int j = 0; j < NIBBLE_W; j++) begin
        bit_c[k*NIBBLE_W + j] = bc;
        bc = s1_q.g[k*NIBBLE_W + j] | (s1_q.p[k*NIBBLE_W + j] & bc);
      end
      carry = s1_q.grp_g[k] | (s1_q.grp_p[k] & carry);
    end
    sum_d  = s1_q.p ^ bit_c;
    cout_d = carry;
    ovf_d  = (s1_q.ctl.msb_a == s1_q.ctl.msb_b) && (sum_d[WIDTH-1] != s1_q.ctl.msb_a);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      s1_q  <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (load1) begin
        v1 <= i_valid;
        if (i_valid) begin
          s1_q <= s1_d;
        end
      end
      if (load2) begin
        v2 <= v1;
        if (v1) begin
          s_q   <= sum_d;
          c_q   <= cout_d;
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign o_valid = v2;
  assign o_s     = s_q;
  assign o_c     = c_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb/tb_cla_adder_pipe.sv - self-checking bench for cla_adder_pipe
module tb_cla_adder_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_c;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_s;
  logic         o_c;
  logic         o_ovf;

  int nchk = 0;
  int nerr = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         ovf;
  } res_t;

  res_t q[$];
  res_t held;
  logic stall_prev = 1'b0;

  cla_adder_pipe #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_c     (i_c),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_s     (o_s),
    .o_c     (o_c),
    .o_ovf   (o_ovf)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    res_t        r;
    int unsigned total;
    int          st;
    total = int'(a) + int'(b) + int'(c);
    st    = int'($signed(a)) + int'($signed(b)) + int'(c);
    r.s   = total[W-1:0];
    r.c   = total[W];
    r.ovf = (st > 32767) || (st < -32768);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: everything accepted and not yet delivered, in acceptance order.
  always @(negedge clk) begin
    if (i_rst) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      chk("ready_vs_occupancy", {31'd0, o_ready}, {31'd0, (q.size() < 2) || i_ready});
      if (o_valid) begin
        if (q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL spurious_valid: got o_valid=1 with o_s=0x%0h expected no pending result", o_s);
        end else begin
          chk("stream_result", {14'd0, o_s, o_c, o_ovf}, {14'd0, q[0]});
        end
        if (stall_prev) chk("stall_hold", {14'd0, o_s, o_c, o_ovf}, {14'd0, held});
      end
      stall_prev = o_valid && !i_ready;
      held       = {o_s, o_c, o_ovf};
      if (o_valid && i_ready && q.size() > 0) void'(q.pop_front());
      if (i_valid && o_ready) q.push_back(model(i_a, i_b, i_c));
    end
  end

  task automatic single(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec, input logic eo, input string name);
    @(posedge clk); #1;
    chk({name, "_ready"}, {31'd0, o_ready}, 32'd1);
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_a = a; i_b = b; i_c = c;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_a = W'($urandom); i_b = W'($urandom); i_c = 1'($urandom);
    chk({name, "_lat1"}, {31'd0, o_valid}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_valid"}, {31'd0, o_valid}, 32'd1);
    chk({name, "_s"}, {16'd0, o_s}, {16'd0, es});
    chk({name, "_c"}, {31'd0, o_c}, {31'd0, ec});
    chk({name, "_ovf"}, {31'd0, o_ovf}, {31'd0, eo});
  endtask

  logic [W-1:0] va[8] = '{16'h0001, 16'hAAAA, 16'h8000, 16'h7FFF, 16'h1234, 16'h0F0F, 16'hFFFF, 16'h4000};
  logic [W-1:0] vb[8] = '{16'hFFFF, 16'h5555, 16'hFFFF, 16'h7FFF, 16'hEDCC, 16'hF0F0, 16'hFFFF, 16'h4000};
  logic         vc[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [15:0]  pat   = 16'b1011_0010_1101_1001;

  initial begin
    int  cyc;
    int  guard;
    logic acc;

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_a = '0; i_b = '0; i_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_s", {16'd0, o_s}, 32'd0);
    chk("rst_c", {31'd0, o_c}, 32'd0);
    chk("rst_ovf", {31'd0, o_ovf}, 32'd0);
    i_rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, o_ready}, 32'd1);

    single(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "basic");
    single(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "full_prop");
    single(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
    single(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "ovf_neg");

    // Backpressure burst: four operands against a stalled consumer.
    @(posedge clk); #1;
    i_ready = 1'b0; i_valid = 1'b1; i_a = 16'd1; i_b = 16'd1; i_c = 1'b0;
    chk("bp_ready0", {31'd0, o_ready}, 32'd1);
    @(posedge clk); #1;
    i_a = 16'd2; i_b = 16'd2;
    chk("bp_ready1", {31'd0, o_ready}, 32'd1);
    chk("bp_valid1", {31'd0, o_valid}, 32'd0);
    @(posedge clk); #1;
    i_a = 16'd3; i_b = 16'd3;
    chk("bp_full_ready", {31'd0, o_ready}, 32'd0);
    chk("bp_full_valid", {31'd0, o_valid}, 32'd1);
    chk("bp_full_s", {16'd0, o_s}, 32'h0002);
    @(posedge clk); #1;
    chk("bp_stall_ready", {31'd0, o_ready}, 32'd0);
    chk("bp_stall_s", {16'd0, o_s}, 32'h0002);
    i_ready = 1'b1;
    #1;
    chk("bp_ready_rise", {31'd0, o_ready}, 32'd1);
    @(posedge clk); #1;
    chk("bp_out2_s", {16'd0, o_s}, 32'h0004);
    i_a = 16'd4; i_b = 16'd4;
    @(posedge clk); #1;
    chk("bp_out3_valid", {31'd0, o_valid}, 32'd1);
    chk("bp_out3_s", {16'd0, o_s}, 32'h0006);
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_out4_valid", {31'd0, o_valid}, 32'd1);
    chk("bp_out4_s", {16'd0, o_s}, 32'h0008);
    @(posedge clk); #1;
    chk("bp_drained", {31'd0, o_valid}, 32'd0);

    // Asynchronous reset with both stages occupied.
    i_ready = 1'b0; i_valid = 1'b1; i_a = 16'd5; i_b = 16'd6; i_c = 1'b0;
    @(posedge clk); #1;
    i_a = 16'd7; i_b = 16'd8;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("mid_valid", {31'd0, o_valid}, 32'd1);
    chk("mid_s", {16'd0, o_s}, 32'h000B);
    #1;
    i_rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("async_rst_s", {16'd0, o_s}, 32'd0);
    @(posedge clk); #1;
    i_rst = 1'b0; i_ready = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, o_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, o_valid}, 32'd0);
    single(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "post_rst");

    // Vector table against a toggling consumer; the scoreboard checks every result.
    @(posedge clk); #1;
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      i_valid = 1'b1; i_a = va[i]; i_b = vb[i]; i_c = vc[i];
      guard = 0;
      acc = 1'b0;
      do begin
        @(negedge clk);
        acc = o_ready;
        @(posedge clk); #1;
        cyc++;
        i_ready = pat[cyc % 16];
        guard++;
      end while (!acc && guard < 50);
      if (!acc) begin
        nchk++;
        nerr++;
        $display("FAIL table_accept_timeout: vector %0d not accepted within 50 cycles", i);
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("table_drain_empty", q.size(), 32'd0);
    chk("table_drain_valid", {31'd0, o_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
